ob_cntrl_trade_exec: RTL
========================

// Module: ob_cntrl_trade_exec
//
// PURPOSE
//  Consumer/initiator for the market-order trade selector. Issues trade_qry,
//  samples the registered trade_vld_r/trade_r decision one cycle later, and
//  commits the selected trade to the bid/ask limit tables and market queues.
//  Presents each executed trade on a valid/ready response channel.
//  Sits in ob_cntrl between the trade selector and the table/queue update ports.
//
// PARAMETERS
//  N_MAX_BURST   16  max trades executed per start before forced return to IDLE
//  CNT_W         32  width of executed-trade and error counters
//
// PORTS
//  clk            in   1      clock
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      pulse: begin a matching burst (ignored unless IDLE)
//  busy           out  1      FSM not in IDLE
//  done           out  1      1-cycle pulse on return to IDLE
//  trade_qry      out  1      query strobe to trade selector
//  trade_vld_r    in   1      selector decision valid (cycle after trade_qry)
//  trade_r        in   ob_pkg::search_result_t  selected trade
//  lm_bid_pop     out  1      remove limit-bid head
//  lm_bid_upd     out  1      overwrite limit-bid head quantity with upd_bid_qty
//  lm_ask_pop     out  1      remove limit-ask head
//  lm_ask_upd     out  1      overwrite limit-ask head quantity with upd_ask_qty
//  mk_bid_pop     out  1      pop market-buy queue head
//  mk_bid_upd     out  1      overwrite market-buy head quantity
//  mk_ask_pop     out  1      pop market-sell queue head
//  mk_ask_upd     out  1      overwrite market-sell head quantity
//  upd_bid_qty    out  ob_pkg::quantity_t  remaining bid-side quantity
//  upd_ask_qty    out  ob_pkg::quantity_t  remaining ask-side quantity
//  rsp_vld        out  1      executed-trade response valid
//  rsp_rdy        in   1      response accepted
//  rsp            out  ob_pkg::trade_rsp_t  {kind, bid_uid, ask_uid, price, quantity}
//  trade_cnt      out  CNT_W  total executed trades (saturating)
//  err_cnt        out  CNT_W  discarded zero-quantity decisions (saturating)
//
// BEHAVIOUR
//  - Reset: FSM=IDLE; every strobe, busy, done, rsp_vld = 0; rsp, upd_* = 0;
//    trade_cnt = err_cnt = 0; burst counter = 0.
//  - FSM: IDLE -start-> QRY -> WAIT -> {APPLY | DONE}; APPLY -> RSP;
//    RSP -(rsp_vld & rsp_rdy)-> QRY if burst_cnt < N_MAX_BURST, else DONE;
//    DONE -> IDLE (done=1 for that one cycle).
//  - QRY: trade_qry=1 for exactly one cycle. WAIT samples trade_vld_r the next
//    cycle. If trade_vld_r=0: book not tradeable -> DONE.
//  - WAIT with trade_vld_r=1: latch trade_r. If quantity==0 and neither side
//    consumed: decision is discarded, err_cnt++, go to DONE (no table writes).
//  - APPLY (1 cycle): exactly one kind flag {mk_ask_lm_bid, lm_ask_mk_bid,
//    mk_ask_mk_bid} selects the table/queue pair. Consumed side -> *_pop=1.
//    The non-consumed side -> *_upd=1 with upd_*_qty = remainder. Both
//    consumed -> two pops, no upd. Never pop and upd the same side at once.
//    If more than one kind flag is set: treat as a discard (err_cnt++, DONE).
//  - Trade price: ask_price for mk_ask_mk_bid and lm_ask_mk_bid; bid_price
//    for mk_ask_lm_bid.
//  - RSP: rsp_vld held until rsp_rdy; rsp stable while vld && !rdy.
//    trade_cnt++ and burst_cnt++ on handshake. The next QRY is issued no
//    earlier than the cycle after the handshake, so table updates from APPLY
//    are visible to the selector.
//  - start while busy: ignored. burst_cnt cleared on entry to QRY from IDLE.
//  - Counters saturate at all-ones.
//  - Asynchronous reset mid-burst: immediate return to IDLE with all strobes
//    low. Partial trades are impossible because APPLY is a single cycle.
//
// STRUCTURE
//  - ob_pkg: trade_rsp_t, trade_kind_t {TK_MK_ASK_LM_BID, TK_LM_ASK_MK_BID,
//    TK_MK_ASK_MK_BID}, exec_state_t enum.
//  - Sub-module ob_cntrl_trade_exec_apply: combinational decode of latched
//    search_result_t -> pop/upd strobes, qty, price, kind, error flag.
//  - Top: FSM, latch register, response register, counters.
//
// TESTING
//  1. start, trade_vld_r=0 at WAIT -> no strobes; done pulse 3 cycles after
//     start; trade_cnt=0.
//  2. mk_ask_lm_bid, bid_consumed=0, ask_consumed=1, qty=5, rem=3 ->
//     mk_ask_pop=1, lm_bid_upd=1, upd_bid_qty=3; rsp.qty=5, price=bid_price.
//  3. lm_ask_mk_bid, both consumed, qty=10 -> lm_ask_pop=mk_bid_pop=1,
//     no upd; trade_cnt=1.
//  4. rsp_rdy held low 4 cycles -> rsp_vld steady, rsp unchanged,
//     no trade_qry until 1 cycle after handshake.
//  5. Selector always valid, N_MAX_BURST=16 -> exactly 16 responses, then
//     done; trade_cnt=16.
//  6. qty=0, neither consumed -> err_cnt=1, no strobes, done. Separately,
//     async rst asserted in RSP -> rsp_vld=0 at once, FSM=IDLE.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types for the ob_cntrl trade execution path.
// Search results, trade responses, table strobes and FSM states.
package ob_pkg;

    localparam int QTY_W   = 16;
    localparam int PRICE_W = 16;
    localparam int UID_W   = 16;

    typedef logic [QTY_W-1:0]   quantity_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [UID_W-1:0]   uid_t;

    typedef enum logic [1:0] {
        TK_MK_ASK_LM_BID = 2'd0,
        TK_LM_ASK_MK_BID = 2'd1,
        TK_MK_ASK_MK_BID = 2'd2
    } trade_kind_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QRY   = 3'd1,
        S_WAIT  = 3'd2,
        S_APPLY = 3'd3,
        S_RSP   = 3'd4,
        S_DONE  = 3'd5
    } exec_state_t;

    // bid_rem/ask_rem hold what is left on a side that was not consumed
    typedef struct packed {
        logic      mk_ask_lm_bid;
        logic      lm_ask_mk_bid;
        logic      mk_ask_mk_bid;
        logic      bid_consumed;
        logic      ask_consumed;
        uid_t      bid_uid;
        uid_t      ask_uid;
        price_t    bid_price;
        price_t    ask_price;
        quantity_t quantity;
        quantity_t bid_rem;
        quantity_t ask_rem;
    } search_result_t;

    typedef struct packed {
        trade_kind_t kind;
        uid_t        bid_uid;
        uid_t        ask_uid;
        price_t      price;
        quantity_t   quantity;
    } trade_rsp_t;

    typedef struct packed {
        logic lm_bid_pop;
        logic lm_bid_upd;
        logic lm_ask_pop;
        logic lm_ask_upd;
        logic mk_bid_pop;
        logic mk_bid_upd;
        logic mk_ask_pop;
        logic mk_ask_upd;
    } strobe_t;

    function automatic logic is_empty(input search_result_t r);
        return (r.quantity == '0) && !r.bid_consumed && !r.ask_consumed;
    endfunction

endpackage

// File: rtl/ob_cntrl_trade_exec_apply.sv
// Decodes a latched selector decision into table strobes, the
// remaining quantities and the response payload.
module ob_cntrl_trade_exec_apply
    import ob_pkg::*;
(
    input  search_result_t trade,
    output strobe_t        strb,
    output quantity_t      upd_bid_qty,
    output quantity_t      upd_ask_qty,
    output trade_rsp_t     rsp,
    output logic           err
);

    logic [2:0] flags;
    logic       bid_pop;
    logic       bid_upd;
    logic       ask_pop;
    logic       ask_upd;

    assign flags   = {trade.mk_ask_mk_bid, trade.lm_ask_mk_bid, trade.mk_ask_lm_bid};
    assign bid_pop = trade.bid_consumed;
    assign bid_upd = !trade.bid_consumed;
    assign ask_pop = trade.ask_consumed;
    assign ask_upd = !trade.ask_consumed;

    always_comb begin
        strb         = '0;
        rsp          = '0;
        err          = 1'b0;
        rsp.bid_uid  = trade.bid_uid;
        rsp.ask_uid  = trade.ask_uid;
        rsp.quantity = trade.quantity;
        rsp.price    = trade.ask_price;
        rsp.kind     = TK_MK_ASK_LM_BID;

        case (flags)
            3'b001: begin
                rsp.kind        = TK_MK_ASK_LM_BID;
                rsp.price       = trade.bid_price;
                strb.lm_bid_pop = bid_pop;
                strb.lm_bid_upd = bid_upd;
                strb.mk_ask_pop = ask_pop;
                strb.mk_ask_upd = ask_upd;
            end
            3'b010: begin
                rsp.kind        = TK_LM_ASK_MK_BID;
                strb.mk_bid_pop = bid_pop;
                strb.mk_bid_upd = bid_upd;
                strb.lm_ask_pop = ask_pop;
                strb.lm_ask_upd = ask_upd;
            end
            3'b100: begin
                rsp.kind        = TK_MK_ASK_MK_BID;
                strb.mk_bid_pop = bid_pop;
                strb.mk_bid_upd = bid_upd;
                strb.mk_ask_pop = ask_pop;
                strb.mk_ask_upd = ask_upd;
            end
            default: err = 1'b1;
        endcase

        if (is_empty(trade)) begin
            err = 1'b1;
        end
        if (err) begin
            strb = '0;
        end

        upd_bid_qty = (bid_upd && !err) ? trade.bid_rem : '0;
        upd_ask_qty = (ask_upd && !err) ? trade.ask_rem : '0;
    end

endmodule

// File: rtl/ob_cntrl_trade_exec.sv
// Market-order trade executor: queries the selector, commits the chosen
// trade to the tables/queues and reports it on a valid/ready channel.
module ob_cntrl_trade_exec
    import ob_pkg::*;
#(
    parameter int N_MAX_BURST = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             trade_qry,
    input  logic             trade_vld_r,
    input  search_result_t   trade_r,
    output logic             lm_bid_pop,
    output logic             lm_bid_upd,
    output logic             lm_ask_pop,
    output logic             lm_ask_upd,
    output logic             mk_bid_pop,
    output logic             mk_bid_upd,
    output logic             mk_ask_pop,
    output logic             mk_ask_upd,
    output quantity_t        upd_bid_qty,
    output quantity_t        upd_ask_qty,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output trade_rsp_t       rsp,
    output logic [CNT_W-1:0] trade_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int BW = $clog2(N_MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(N_MAX_BURST);

    exec_state_t    state;
    search_result_t trade_q;
    logic [BW-1:0]  burst_cnt;
    logic [BW-1:0]  burst_nxt;

    strobe_t    dec_strb;
    quantity_t  dec_bid_qty;
    quantity_t  dec_ask_qty;
    trade_rsp_t dec_rsp;
    logic       dec_err;
    logic       apply_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ob_cntrl_trade_exec_apply u_apply (
        .trade       (trade_q),
        .strb        (dec_strb),
        .upd_bid_qty (dec_bid_qty),
        .upd_ask_qty (dec_ask_qty),
        .rsp         (dec_rsp),
        .err         (dec_err)
    );

    // Strobes derive only from registered state, so reset drops them at once
    assign apply_ok    = (state == S_APPLY) && !dec_err;
    assign lm_bid_pop  = apply_ok && dec_strb.lm_bid_pop;
    assign lm_bid_upd  = apply_ok && dec_strb.lm_bid_upd;
    assign lm_ask_pop  = apply_ok && dec_strb.lm_ask_pop;
    assign lm_ask_upd  = apply_ok && dec_strb.lm_ask_upd;
    assign mk_bid_pop  = apply_ok && dec_strb.mk_bid_pop;
    assign mk_bid_upd  = apply_ok && dec_strb.mk_bid_upd;
    assign mk_ask_pop  = apply_ok && dec_strb.mk_ask_pop;
    assign mk_ask_upd  = apply_ok && dec_strb.mk_ask_upd;
    assign upd_bid_qty = apply_ok ? dec_bid_qty : '0;
    assign upd_ask_qty = apply_ok ? dec_ask_qty : '0;

    assign burst_nxt = burst_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            trade_q   <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trade_qry <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp       <= '0;
            trade_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            trade_qry <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_QRY;
                        busy      <= 1'b1;
                        trade_qry <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                S_QRY: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!trade_vld_r) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (is_empty(trade_r)) begin
                        trade_q <= trade_r;
                        err_cnt <= sat_inc(err_cnt);
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        trade_q <= trade_r;
                        state   <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (dec_err) begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        rsp     <= dec_rsp;
                        rsp_vld <= 1'b1;
                        state   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_rdy) begin
                        rsp_vld   <= 1'b0;
                        trade_cnt <= sat_inc(trade_cnt);
                        burst_cnt <= burst_nxt;
                        if (burst_nxt < BURST_MAX) begin
                            state     <= S_QRY;
                            trade_qry <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
